// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if
// Bundles the read, write, issue and flush signals of the scoreboarded
// register file so the pipeline and the register file share one port list.
//   raddr      read addresses, port i = raddr[i*AW +: AW]
//   rdata      read data, port i = rdata[i*WIDTH +: WIDTH]
//   rbusy      per-port "register still waiting on an outstanding write"
//   hazard     OR of rbusy
//   we0/waddr0/wdata0   write port 0 (ALU writeback)
//   we1/waddr1/wdata1   write port 1 (load writeback)
//   iss_valid/iss_addr  destination register of an instruction issued now
//   flush      discard every outstanding write (taken branch or jump)
// Modports: master = pipeline side, slave = register file side.
interface reg_file_sb_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]    raddr;
    logic [NREAD*WIDTH-1:0] rdata;
    logic [NREAD-1:0]       rbusy;
    logic                   hazard;
    logic                   we0;
    logic [AW-1:0]          waddr0;
    logic [WIDTH-1:0]       wdata0;
    logic                   we1;
    logic [AW-1:0]          waddr1;
    logic [WIDTH-1:0]       wdata1;
    logic                   iss_valid;
    logic [AW-1:0]          iss_addr;
    logic                   flush;

    modport master (
        output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1,
               iss_valid, iss_addr, flush,
        input  rdata, rbusy, hazard
    );

    modport slave (
        input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1,
               iss_valid, iss_addr, flush,
        output rdata, rbusy, hazard
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Parametrised register file with two write ports, write-through bypass,
// optional hardwired zero register and a pending-write scoreboard used by
// the RF stage to stall on load-use hazards.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears registers and pending bits
//         and forces rdata/rbusy/hazard to 0 while held
//   bus   reg_file_sb_if slave modport carrying the read, write, issue and
//         flush signals
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 0
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic             w0_en;
    logic             w1_en;
    logic             iss_en;

    // Writes and issues aimed at a hardwired zero register are dropped here,
    // so storage, bypass and scoreboard never see them.
    assign w0_en  = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
    assign w1_en  = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
    assign iss_en = bus.iss_valid && !((ZERO_REG != 0) && (bus.iss_addr == '0));

    // Register storage. W1 is written last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (w0_en) begin
                regs[bus.waddr0] <= bus.wdata0;
            end
            if (w1_en) begin
                regs[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    // Scoreboard update. Flush overrides everything; otherwise writes clear
    // first and the issue sets afterwards, because a write landing in the
    // issue cycle belongs to an older instruction.
    always_comb begin
        pending_next = pending;
        if (bus.flush) begin
            pending_next = '0;
        end else begin
            if (w0_en) begin
                pending_next[bus.waddr0] = 1'b0;
            end
            if (w1_en) begin
                pending_next[bus.waddr1] = 1'b0;
            end
            if (iss_en) begin
                pending_next[bus.iss_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Read ports: W1 bypass, then W0 bypass, then stored value. A read that
    // is satisfied by a same-cycle write is not reported busy.
    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0] ra;
        logic          is_zero;
        logic          hit0;
        logic          hit1;

        assign ra      = bus.raddr[i*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign hit0    = w0_en && (bus.waddr0 == ra);
        assign hit1    = w1_en && (bus.waddr1 == ra);

        assign bus.rdata[i*WIDTH +: WIDTH] = (rst || is_zero) ? '0 :
                                             hit1             ? bus.wdata1 :
                                             hit0             ? bus.wdata0 :
                                                                regs[ra];
        assign bus.rbusy[i] = !rst && !is_zero && pending[ra] && !hit0 && !hit1;
    end

    assign bus.hazard = |bus.rbusy;
endmodule
